// File: rtl/sec_to_hms_if.sv
// Request/result bundle for the seconds-of-day to hh:mm:ss converter.
// The master drives load/sec_in. The slave (the converter) returns the results and status.
interface sec_to_hms_if;
  logic        load;
  logic [16:0] sec_in;
  logic [5:0]  hh;
  logic [5:0]  mm;
  logic [5:0]  ss;
  logic [7:0]  hh_bcd;
  logic [7:0]  mm_bcd;
  logic [7:0]  ss_bcd;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output load, sec_in,
    input  hh, mm, ss, hh_bcd, mm_bcd, ss_bcd, busy, done, err
  );

  modport slave (
    input  load, sec_in,
    output hh, mm, ss, hh_bcd, mm_bcd, ss_bcd, busy, done, err
  );
endinterface

// File: rtl/sec_to_hms.sv
// Converts a seconds-of-day count into binary and BCD hh:mm:ss.
// It uses repeated subtraction, taking one cycle per hour and one cycle per minute.
module sec_to_hms #(
  parameter logic [16:0] MAX_SEC = 17'd86399
) (
  input  logic        clk,
  input  logic        reset,
  sec_to_hms_if.slave bus
);

  localparam logic [16:0] SEC_PER_HOUR = 17'd3600;
  localparam logic [16:0] SEC_PER_MIN  = 17'd60;

  typedef enum logic [1:0] {IDLE, HOURS, MINUTES, COMMIT} state_t;

  state_t      state;
  state_t      state_next;
  logic [16:0] rem;
  logic [5:0]  hour_cnt;
  logic [5:0]  min_cnt;
  logic [5:0]  hh_q;
  logic [5:0]  mm_q;
  logic [5:0]  ss_q;
  logic [7:0]  hh_bcd_q;
  logic [7:0]  mm_bcd_q;
  logic [7:0]  ss_bcd_q;
  logic        busy_q;
  logic        done_q;
  logic        err_q;

  // Values never exceed 59, so the tens digit fits in 4 bits.
  function automatic logic [7:0] to_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    tens = 4'(v / 6'd10);
    ones = 4'(v - 6'(tens) * 6'd10);
    return {tens, ones};
  endfunction

  // NOTE: state and datapath registers use non-blocking assignments only.
  // Each always_ff block therefore sees the values from the previous cycle, whatever the statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  // NOTE: state_next gets a default before the case statement.
  // A path that does not assign it then cannot infer a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (bus.load)             state_next = HOURS;
      HOURS:   if (rem < SEC_PER_HOUR)   state_next = MINUTES;
      MINUTES: if (rem < SEC_PER_MIN)    state_next = COMMIT;
      COMMIT:                            state_next = IDLE;
      default:                           state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rem      <= '0;
      hour_cnt <= '0;
      min_cnt  <= '0;
      hh_q     <= '0;
      mm_q     <= '0;
      ss_q     <= '0;
      hh_bcd_q <= '0;
      mm_bcd_q <= '0;
      ss_bcd_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.load) begin
            // An out-of-range request is clamped to the last second of the day and flagged.
            if (bus.sec_in > MAX_SEC) begin
              rem   <= MAX_SEC;
              err_q <= 1'b1;
            end else begin
              rem   <= bus.sec_in;
              err_q <= 1'b0;
            end
            hour_cnt <= '0;
            min_cnt  <= '0;
            busy_q   <= 1'b1;
          end
        end
        HOURS: begin
          if (rem >= SEC_PER_HOUR) begin
            rem      <= rem - SEC_PER_HOUR;
            hour_cnt <= hour_cnt + 6'd1;
          end
        end
        MINUTES: begin
          if (rem >= SEC_PER_MIN) begin
            rem     <= rem - SEC_PER_MIN;
            min_cnt <= min_cnt + 6'd1;
          end
        end
        COMMIT: begin
          // At this point rem is below 60.
          hh_q     <= hour_cnt;
          mm_q     <= min_cnt;
          ss_q     <= rem[5:0];
          hh_bcd_q <= to_bcd(hour_cnt);
          mm_bcd_q <= to_bcd(min_cnt);
          ss_bcd_q <= to_bcd(rem[5:0]);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign bus.hh     = hh_q;
  assign bus.mm     = mm_q;
  assign bus.ss     = ss_q;
  assign bus.hh_bcd = hh_bcd_q;
  assign bus.mm_bcd = mm_bcd_q;
  assign bus.ss_bcd = ss_bcd_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.err    = err_q;

endmodule

// File: tb/tb_sec_to_hms.sv
// Scoreboard bench for sec_to_hms: the driver pushes reference results, and a negedge monitor pops and compares them.
module tb_sec_to_hms;

  localparam int MAX_SEC = 86399;

  typedef struct {
    int h;
    int m;
    int s;
    int e;
    int due;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   n_cmp;
  int   n_fail;
  exp_t q[$];
  exp_t last;
  int   err_model;

  sec_to_hms_if bus ();

  sec_to_hms #(.MAX_SEC(17'd86399)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", name, act, act, exp, exp, cyc);
    end
  endtask

  function automatic int bcd(input int v);
    return ((v / 10) << 4) | (v % 10);
  endfunction

  function automatic exp_t model(input int sec, input int load_edge);
    exp_t r;
    int   t;
    t     = (sec > MAX_SEC) ? MAX_SEC : sec;
    r.e   = (sec > MAX_SEC) ? 1 : 0;
    r.h   = t / 3600;
    r.m   = (t % 3600) / 60;
    r.s   = t % 60;
    r.due = load_edge + r.h + r.m + 3;
    return r;
  endfunction

  task automatic compare_outputs(input string tag, input exp_t x);
    check({tag, " hh"},     int'(bus.hh),     x.h);
    check({tag, " mm"},     int'(bus.mm),     x.m);
    check({tag, " ss"},     int'(bus.ss),     x.s);
    check({tag, " hh_bcd"}, int'(bus.hh_bcd), bcd(x.h));
    check({tag, " mm_bcd"}, int'(bus.mm_bcd), bcd(x.m));
    check({tag, " ss_bcd"}, int'(bus.ss_bcd), bcd(x.s));
  endtask

  // Monitor: checks the result and latency on done. On every other cycle it checks that the outputs still hold the last result.
  always @(negedge clk) begin
    if (reset) begin
      if (bus.done) begin
        if (q.size() == 0) begin
          check("unexpected done", 1, 0);
        end else begin
          exp_t x;
          x = q.pop_front();
          compare_outputs("result", x);
          check("done latency", cyc, x.due);
          check("busy at done", int'(bus.busy), 0);
          last = x;
        end
      end else begin
        compare_outputs("hold", last);
        check("busy", int'(bus.busy), (q.size() != 0) ? 1 : 0);
      end
      check("err", int'(bus.err), err_model);
    end
  end

  // Call at a negedge. The load is sampled on the following posedge.
  task automatic issue(input int sec);
    exp_t x;
    bus.load   = 1'b1;
    bus.sec_in = 17'(sec);
    @(posedge clk);
    #1;
    x = model(sec, cyc);
    q.push_back(x);
    err_model  = x.e;
    bus.load   = 1'b0;
    bus.sec_in = 17'($urandom_range(0, 131071));
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && q.size() != 0; i++) @(negedge clk);
    if (q.size() != 0) begin
      check("timeout waiting for done", 0, 1);
      q.delete();
    end
    @(negedge clk);
  endtask

  task automatic wait_done();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      seen = bus.done;
    end
    if (!seen) check("timeout waiting for done", 0, 1);
  endtask

  initial begin
    cyc        = 0;
    n_cmp      = 0;
    n_fail     = 0;
    err_model  = 0;
    last       = '{default: 0};
    reset      = 1'b0;
    bus.load   = 1'b0;
    bus.sec_in = '0;

    repeat (2) @(negedge clk);
    #1;
    compare_outputs("reset", last);
    check("reset busy", int'(bus.busy), 0);
    check("reset done", int'(bus.done), 0);
    check("reset err",  int'(bus.err),  0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Directed cases: minimum, mixed, maximum, clamped, then recovery from the error.
    issue(0);      wait_idle();
    issue(3661);   wait_idle();
    issue(86399);  wait_idle();
    issue(100000); wait_idle();
    issue(45296);  wait_idle();

    // A second load while busy is ignored.
    issue(5025);
    repeat (3) @(negedge clk);
    bus.load   = 1'b1;
    bus.sec_in = 17'd61;
    @(negedge clk);
    bus.load   = 1'b0;
    wait_idle();

    // Back-to-back: the next load is presented in the done cycle.
    issue(7322);
    wait_done();
    issue(3599);
    wait_idle();

    // Reset during HOURS aborts the conversion without a done pulse or an output update.
    issue(7200);
    @(negedge clk);
    reset     = 1'b0;
    q.delete();
    last      = '{default: 0};
    err_model = 0;
    #1;
    compare_outputs("abort", last);
    check("abort busy", int'(bus.busy), 0);
    check("abort done", int'(bus.done), 0);
    check("abort err",  int'(bus.err),  0);
    @(negedge clk);
    reset = 1'b1;
    repeat (4) @(negedge clk);
    issue(59);
    wait_idle();

    // Random traffic, with both idle gaps and back-to-back loads.
    for (int n = 0; n < 30; n++) begin
      if (q.size() != 0 && $urandom_range(0, 1) == 1) begin
        wait_done();
      end else begin
        wait_idle();
        repeat ($urandom_range(0, 3)) begin
          bus.sec_in = 17'($urandom_range(0, 131071));
          @(negedge clk);
        end
      end
      issue(($urandom_range(0, 7) == 0) ? $urandom_range(86400, 131071)
                                        : $urandom_range(0, MAX_SEC));
    end
    wait_idle();
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/sec_to_hms.md
SEC_TO_HMS -- requirements
Module: sec_to_hms

Interface
REQ-001 Parameter: MAX_SEC, default 17'd86399, largest valid seconds-of-day value (23:59:59).
REQ-002 Port: clk  input  1  system clock; all state changes on the rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-low; 0 forces the reset state immediately.
REQ-004 Port: load  input  1  start request; sampled on the rising edge of clk.
REQ-005 Port: sec_in  input  17  total seconds value (hh*3600 + mm*60 + ss), sampled with load.
REQ-006 Port: hh  output  6  hours, binary, 0..23.
REQ-007 Port: mm  output  6  minutes, binary, 0..59.
REQ-008 Port: ss  output  6  seconds, binary, 0..59.
REQ-009 Port: hh_bcd  output  8  hours BCD, {tens, ones}.
REQ-010 Port: mm_bcd  output  8  minutes BCD, {tens, ones}.
REQ-011 Port: ss_bcd  output  8  seconds BCD, {tens, ones}.
REQ-012 Port: busy  output  1  high while a conversion is in progress.
REQ-013 Port: done  output  1  one-cycle pulse; high in the cycle the results first become valid.
REQ-014 Port: err  output  1  sticky range-error flag for the last accepted request.

Function
REQ-015 States: IDLE, HOURS, MINUTES, COMMIT; reset state is IDLE.
REQ-016 IDLE with load=1 and sec_in <= MAX_SEC: capture rem = sec_in, clear the hour and minute counters, set err=0 and busy=1, go to HOURS.
REQ-017 IDLE with load=1 and sec_in > MAX_SEC: capture rem = MAX_SEC, set err=1 and busy=1, go to HOURS.
REQ-018 HOURS: while rem >= 3600, subtract 3600 from rem and increment the hour counter each cycle; otherwise go to MINUTES.
REQ-019 MINUTES: while rem >= 60, subtract 60 from rem and increment the minute counter each cycle; otherwise go to COMMIT.
REQ-020 COMMIT: register hh, mm, ss (ss = rem) and their BCD forms (tens = v/10, ones = v%10); pulse done=1; set busy=0; go to IDLE.
REQ-021 Latency: done is high exactly H+M+3 rising edges after the edge that samples load, where H and M are the resulting hours and minutes (worst case 85 edges).
REQ-022 hh/mm/ss and the BCD outputs hold their previous values until COMMIT, and are never updated mid-conversion.
REQ-023 load is ignored while busy=1; it has no effect on the conversion in progress.
REQ-024 load=1 in the cycle done=1 (state IDLE) is accepted normally, giving back-to-back conversions.
REQ-025 All subtraction uses 17-bit unsigned arithmetic; rem never underflows.
REQ-026 err holds its value until the next accepted load.
REQ-027 A sec_in change without load has no effect on any output.

Reset
REQ-028 When reset=0, the block SHALL set state=IDLE, rem=0, all counters=0, hh=mm=ss=0, all BCD outputs=8'h00, busy=0, done=0 and err=0.
REQ-029 Reset asserted mid-conversion SHALL abort the conversion with no done pulse and no output update.
REQ-030 After reset is released, the first rising edge with load=1 SHALL start a conversion.

Verification
REQ-031 load with sec_in=0 -> done after 3 edges; hh=mm=ss=0; BCD outputs 00/00/00; err=0.
REQ-032 load with sec_in=3661 -> done after 5 edges; 01:01:01; hh_bcd=8'h01, mm_bcd=8'h01, ss_bcd=8'h01.
REQ-033 load with sec_in=86399 -> done after 85 edges; hh_bcd=8'h23, mm_bcd=8'h59, ss_bcd=8'h59; busy high for the entire interval.
REQ-034 load with sec_in=100000 -> err=1; outputs 23:59:59; a following load with sec_in=45296 -> err=0; outputs 12:34:56.
REQ-035 Second load pulse while busy -> ignored; a single done pulse; results match the first sec_in.
REQ-036 reset=0 during HOURS with sec_in=7200 -> immediate zero outputs, busy=0, no done pulse; a fresh load with sec_in=59 -> 00:00:59 after 3 edges.
